led_frame_writer: RTL

Initiator for the LED matrix update port: accepts a full on/off frame plus a brightness value and replays it into `led_matrix` as a sequence of single-LED `sel`/`sel_addr`/`en` writes, pacing each write on `done_tick`. It sits between the application logic and `led_matrix`, so callers deal in whole frames instead of per-LED handshakes. A per-write timeout keeps a stalled matrix from hanging the writer.

---
 rtl/led_pkg.sv | 21 ++
 rtl/led_timeout_counter.sv | 32 +++
 rtl/led_frame_writer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the LED frame writer: FSM states, default geometry
// and the address-width helper.
package led_pkg;

    localparam int unsigned LED_DEF_N = 2;
    localparam int unsigned LED_DEF_M = 2;
    localparam int unsigned LED_COUNT = LED_DEF_N * LED_DEF_M;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_FINISH = 2'd3
    } led_state_e;

    // Width of the matrix select address (n bits followed by m bits)
    function automatic int unsigned led_addr_w(input int unsigned n_bits, input int unsigned m_bits);
        return n_bits + m_bits;
    endfunction

endpackage

// File: rtl/led_timeout_counter.sv
// Per-write wait counter: counts cycles spent waiting for done_tick and
// flags the cycle in which the count reaches 2^TIMEOUT_BITS-1.
module led_timeout_counter #(
    parameter int unsigned TIMEOUT_BITS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expire_c
);

    localparam logic [TIMEOUT_BITS-1:0] LIMIT = '1;
    localparam logic [TIMEOUT_BITS-1:0] ONE   = TIMEOUT_BITS'(1);

    logic [TIMEOUT_BITS-1:0] cnt;

    // Count completed wait cycles, saturating at the limit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (count_en && (cnt != LIMIT)) begin
            cnt <= cnt + ONE;
        end
    end

    // The current counting cycle is the one that brings the count to the limit
    assign expire_c = count_en && (cnt == (LIMIT - ONE));

endmodule

// File: rtl/led_frame_writer.sv
// Replays a whole LED frame into led_matrix as single-LED sel/sel_addr/en
// writes, paced by done_tick, with a per-write timeout.
// Optional feature: define LED_FRAME_WRITER_DIFF_EN to keep a shadow of the
// acknowledged matrix contents and write only LEDs that differ from it.
module led_frame_writer
    import led_pkg::*;
#(
    parameter int unsigned LEDS_N       = LED_DEF_N,
    parameter int unsigned LEDS_M       = LED_DEF_M,
    parameter int unsigned N_BITS       = 2,
    parameter int unsigned M_BITS       = 2,
    parameter int unsigned PWM_BITS     = 1,
    parameter int unsigned TIMEOUT_BITS = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [LEDS_N*LEDS_M-1:0]            frame,
    input  logic [PWM_BITS-1:0]                 brightness_in,
    input  logic                                start,
    output logic                                busy,
    output logic                                done,
    output logic                                err,
    output logic [PWM_BITS-1:0]                 brightness,
    output logic [led_addr_w(N_BITS,M_BITS)-1:0] sel_addr,
    output logic                                sel,
    output logic                                en,
    input  logic                                done_tick
);

    localparam int unsigned NUM_LEDS = LEDS_N * LEDS_M;
    localparam int unsigned ADDR_W   = led_addr_w(N_BITS, M_BITS);
    localparam int unsigned IDX_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEDS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    led_state_e            state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_LEDS-1:0]   frame_q, frame_d;
    logic [PWM_BITS-1:0]   brightness_d;
    logic [ADDR_W-1:0]     sel_addr_d;
    logic                  sel_d, en_d, busy_d, done_d, err_d;
    logic                  advance_c, issue_c, need_c, expire_c;
    logic [IDX_W-1:0]      issue_idx_c;
`ifdef LED_FRAME_WRITER_DIFF_EN
    logic [NUM_LEDS-1:0]   shadow_q, shadow_d;
`endif

    led_timeout_counter #(
        .TIMEOUT_BITS (TIMEOUT_BITS)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .clear    (state_q != ST_WAIT),
        .count_en (state_q == ST_WAIT),
        .expire_c (expire_c)
    );

    // Next state and next registered outputs; outputs are computed one cycle
    // ahead so the strobe for an index appears in the cycle it is issued
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        frame_d      = frame_q;
        brightness_d = brightness;
        sel_addr_d   = sel_addr;
        sel_d        = 1'b0;
        en_d         = en;
        busy_d       = busy;
        done_d       = 1'b0;
        err_d        = err;
        advance_c    = 1'b0;
        issue_c      = 1'b0;
        need_c       = 1'b0;
        issue_idx_c  = '0;
`ifdef LED_FRAME_WRITER_DIFF_EN
        shadow_d     = shadow_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    frame_d      = frame;
                    brightness_d = brightness_in;
                    err_d        = 1'b0;
                    busy_d       = 1'b1;
                    issue_c      = 1'b1;
                    issue_idx_c  = '0;
                end
            end
            ST_ISSUE: begin
                // A strobe this cycle means a write is in flight; otherwise the index was skipped
                if (sel) begin
                    state_d = ST_WAIT;
                end else begin
                    advance_c = 1'b1;
                end
            end
            ST_WAIT: begin
                // An acknowledge in the expiry cycle still counts as success
                if (done_tick) begin
`ifdef LED_FRAME_WRITER_DIFF_EN
                    shadow_d[idx_q] = frame_q[idx_q];
`endif
                    advance_c = 1'b1;
                end else if (expire_c) begin
                    err_d     = 1'b1;
                    advance_c = 1'b1;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (advance_c) begin
            if (idx_q == LAST_IDX) begin
                state_d = ST_FINISH;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end else begin
                issue_c     = 1'b1;
                issue_idx_c = idx_q + IDX_ONE;
            end
        end

        if (issue_c) begin
            state_d = ST_ISSUE;
            idx_d   = issue_idx_c;
`ifdef LED_FRAME_WRITER_DIFF_EN
            need_c  = frame_d[issue_idx_c] != shadow_q[issue_idx_c];
`else
            need_c  = 1'b1;
`endif
            if (need_c) begin
                sel_d      = 1'b1;
                sel_addr_d = ADDR_W'(issue_idx_c);
                en_d       = frame_d[issue_idx_c];
            end
        end
    end

    // State, latched frame and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            frame_q    <= '0;
            brightness <= '0;
            sel_addr   <= '0;
            sel        <= 1'b0;
            en         <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            frame_q    <= frame_d;
            brightness <= brightness_d;
            sel_addr   <= sel_addr_d;
            sel        <= sel_d;
            en         <= en_d;
            busy       <= busy_d;
            done       <= done_d;
            err        <= err_d;
        end
    end

`ifdef LED_FRAME_WRITER_DIFF_EN
    // Shadow of the LED values the matrix has acknowledged
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end
`endif

endmodule
